// File: rtl/mult_16_16_arbiter.sv
// Round-robin scheduler sharing one free-running pipelined multiplier among NREQ clients.
// A tag pipeline, matched to the multiplier latency, routes each product back to its issuer.
module mult_16_16_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 3,
  parameter int W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic              flush,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  output logic              mul_en,
  input  logic [W-1:0]      mul_out,
  output logic [NREQ-1:0]   resp_valid,
  output logic [W-1:0]      resp_data,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] ptr_nxt;
  logic          found;
  logic          issue;
  logic [LAT-1:0] vld_p;
  logic [PW-1:0]  tag_p [LAT];

  assign busy = |vld_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (flush) state_nxt = DRAIN;
      DRAIN:   if (!flush && !busy) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int cand;
    cand      = 0;
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = PW'(cand);
      end
    end
  end

  // rst gates the grant so the multiplier sees nothing while reset is held.
  always_comb begin
    issue     = found && (state == RUN) && !flush && !rst;
    req_ready = '0;
    mul_en    = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    if (issue) begin
      req_ready[grant_idx] = 1'b1;
      mul_en               = 1'b1;
      mul_a                = req_a[grant_idx*W +: W];
      mul_b                = req_b[grant_idx*W +: W];
    end
    ptr_nxt = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rr_ptr <= '0;
    else if (issue) rr_ptr <= ptr_nxt;
  end

  // Tag pipeline stage boundaries: advances every cycle, bubbles included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= issue;
      for (int k = 1; k < LAT; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_p[0] <= grant_idx;
    for (int k = 1; k < LAT; k++) tag_p[k] <= tag_p[k-1];
  end

  always_comb begin
    resp_valid = '0;
    resp_data  = '0;
    if (vld_p[LAT-1]) begin
      resp_valid[tag_p[LAT-1]] = 1'b1;
      resp_data                = mul_out;
    end
  end

endmodule

// File: tb/tb_mult_16_16_arbiter.sv
// Directed bench for mult_16_16_arbiter with a latency-matched multiplier model.
module tb_mult_16_16_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int W    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic              flush;
  logic [W-1:0]      mul_a, mul_b, mul_out;
  logic              mul_en;
  logic [NREQ-1:0]   resp_valid;
  logic [W-1:0]      resp_data;
  logic              busy;

  int checks = 0;
  int failures = 0;

  mult_16_16_arbiter #(.NREQ(NREQ), .LAT(LAT), .W(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .flush(flush), .mul_a(mul_a), .mul_b(mul_b),
    .mul_en(mul_en), .mul_out(mul_out), .resp_valid(resp_valid),
    .resp_data(resp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Free-running multiplier: idle slots carry a marker value, never cleared by reset.
  logic [W-1:0] mp [LAT];
  always_ff @(posedge clk) begin
    mp[0] <= mul_en ? W'(32'(mul_a) * 32'(mul_b)) : 16'hDEAD;
    for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
  end
  assign mul_out = mp[LAT-1];

  typedef struct {
    logic [3:0]  v;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  rdy;
    logic        en;
    logic [15:0] ma;
    logic [15:0] mb;
    logic [3:0]  rv;
    logic [15:0] rd;
    logic        bsy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] v, input logic [63:0] a, input logic [63:0] b,
                     input logic [3:0] rdy, input logic en, input logic [15:0] ma,
                     input logic [15:0] mb, input logic [3:0] rv, input logic [15:0] rd,
                     input logic bsy);
    vec_t e;
    e.v = v; e.a = a; e.b = b; e.rdy = rdy; e.en = en; e.ma = ma; e.mb = mb;
    e.rv = rv; e.rd = rd; e.bsy = bsy;
    tbl.push_back(e);
  endtask

  task automatic idle(input logic [3:0] rv, input logic [15:0] rd, input logic bsy);
    add(4'b0, 64'h0, 64'h0, 4'b0, 1'b0, 16'h0, 16'h0, rv, rd, bsy);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] rdy, input logic en,
                         input logic [15:0] ma, input logic [15:0] mb, input logic [3:0] rv,
                         input logic [15:0] rd, input logic bsy);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
    chk({tag, ".mul_en"}, 32'(mul_en), 32'(en));
    chk({tag, ".mul_a"}, 32'(mul_a), 32'(ma));
    chk({tag, ".mul_b"}, 32'(mul_b), 32'(mb));
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(rv));
    chk({tag, ".resp_data"}, 32'(resp_data), 32'(rd));
    chk({tag, ".busy"}, 32'(busy), 32'(bsy));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] ALL_A = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [63:0] ALL_B = {16'd10, 16'd10, 16'd10, 16'd10};

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; flush = 1'b0;

    // Single request, truncation, full rotation, pointer-ordered pick, idle pointer hold
    add(4'b0100, {16'd0, 16'd2, 32'd0}, {16'd0, 16'd3, 32'd0}, 4'b0100, 1, 16'd2, 16'd3, 4'b0, 16'd0, 0);
    idle(4'b0, 16'd0, 1);
    idle(4'b0, 16'd0, 1);
    idle(4'b0100, 16'd6, 1);
    idle(4'b0, 16'd0, 0);
    add(4'b1000, {16'hFFFF, 48'd0}, {16'd2, 48'd0}, 4'b1000, 1, 16'hFFFF, 16'd2, 4'b0, 16'd0, 0);
    add(4'b1111, ALL_A, ALL_B, 4'b0001, 1, 16'd1, 16'd10, 4'b0, 16'd0, 1);
    add(4'b1111, ALL_A, ALL_B, 4'b0010, 1, 16'd2, 16'd10, 4'b0, 16'd0, 1);
    add(4'b1111, ALL_A, ALL_B, 4'b0100, 1, 16'd3, 16'd10, 4'b1000, 16'hFFFE, 1);
    add(4'b1111, ALL_A, ALL_B, 4'b1000, 1, 16'd4, 16'd10, 4'b0001, 16'd10, 1);
    add(4'b1111, ALL_A, ALL_B, 4'b0001, 1, 16'd1, 16'd10, 4'b0010, 16'd20, 1);
    add(4'b1001, {16'd7, 32'd0, 16'd5}, {16'd3, 32'd0, 16'd9}, 4'b1000, 1, 16'd7, 16'd3, 4'b0100, 16'd30, 1);
    add(4'b1001, {16'd7, 32'd0, 16'd5}, {16'd3, 32'd0, 16'd9}, 4'b0001, 1, 16'd5, 16'd9, 4'b1000, 16'd40, 1);
    idle(4'b0001, 16'd10, 1);
    idle(4'b1000, 16'd21, 1);
    idle(4'b0001, 16'd45, 1);
    idle(4'b0, 16'd0, 0);
    add(4'b1100, {16'd8, 16'd6, 32'd0}, {16'd1, 16'd7, 32'd0}, 4'b0100, 1, 16'd6, 16'd7, 4'b0, 16'd0, 0);
    idle(4'b0, 16'd0, 1);
    idle(4'b0, 16'd0, 1);
    idle(4'b0100, 16'd42, 1);
    idle(4'b0, 16'd0, 0);
    // Same requester issues while its earlier result returns
    add(4'b0001, {48'd0, 16'd3}, {48'd0, 16'd5}, 4'b0001, 1, 16'd3, 16'd5, 4'b0, 16'd0, 0);
    idle(4'b0, 16'd0, 1);
    idle(4'b0, 16'd0, 1);
    add(4'b0001, {48'd0, 16'd4}, {48'd0, 16'd4}, 4'b0001, 1, 16'd4, 16'd4, 4'b0001, 16'd15, 1);
    idle(4'b0, 16'd0, 1);
    idle(4'b0, 16'd0, 1);
    idle(4'b0001, 16'd16, 1);
    idle(4'b0, 16'd0, 0);

    next_cycle();
    next_cycle();
    @(negedge clk);
    chk_all("reset", 4'b0, 0, 16'd0, 16'd0, 4'b0, 16'd0, 0);
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      req_valid = tbl[i].v; req_a = tbl[i].a; req_b = tbl[i].b;
      @(negedge clk);
      chk_all($sformatf("row%0d", i), tbl[i].rdy, tbl[i].en, tbl[i].ma, tbl[i].mb,
              tbl[i].rv, tbl[i].rd, tbl[i].bsy);
      next_cycle();
    end

    // Flush: three issues from rr_ptr=1, then drain
    req_valid = 4'b1111;
    req_a = {16'd4, 16'd3, 16'd2, 16'd1};
    req_b = {16'd2, 16'd2, 16'd2, 16'd2};
    @(negedge clk); chk_all("fl_i0", 4'b0010, 1, 16'd2, 16'd2, 4'b0, 16'd0, 0); next_cycle();
    @(negedge clk); chk_all("fl_i1", 4'b0100, 1, 16'd3, 16'd2, 4'b0, 16'd0, 1); next_cycle();
    @(negedge clk); chk_all("fl_i2", 4'b1000, 1, 16'd4, 16'd2, 4'b0, 16'd0, 1); next_cycle();
    flush = 1'b1;
    @(negedge clk); chk_all("fl_d0", 4'b0, 0, 16'd0, 16'd0, 4'b0010, 16'd4, 1); next_cycle();
    @(negedge clk); chk_all("fl_d1", 4'b0, 0, 16'd0, 16'd0, 4'b0100, 16'd6, 1); next_cycle();
    @(negedge clk); chk_all("fl_d2", 4'b0, 0, 16'd0, 16'd0, 4'b1000, 16'd8, 1); next_cycle();
    flush = 1'b0;
    @(negedge clk); chk_all("fl_d3", 4'b0, 0, 16'd0, 16'd0, 4'b0, 16'd0, 0); next_cycle();
    @(negedge clk); chk_all("fl_run", 4'b0001, 1, 16'd1, 16'd2, 4'b0, 16'd0, 0); next_cycle();

    // Reset with operations in flight
    req_valid = 4'b0010; req_a = {48'd0, 16'd5, 16'd0} << 0; req_b = {32'd0, 16'd5, 16'd0};
    req_a = {32'd0, 16'd5, 16'd0};
    @(negedge clk); chk_all("rs_i0", 4'b0010, 1, 16'd5, 16'd5, 4'b0, 16'd0, 1); next_cycle();
    req_valid = 4'b0100; req_a = {16'd0, 16'd6, 32'd0}; req_b = {16'd0, 16'd6, 32'd0};
    @(negedge clk); chk_all("rs_i1", 4'b0100, 1, 16'd6, 16'd6, 4'b0, 16'd0, 1); next_cycle();
    req_valid = 4'b1111; req_a = ALL_A; req_b = ALL_B;
    rst = 1'b1;
    @(negedge clk); chk_all("rs_hold", 4'b0, 0, 16'd0, 16'd0, 4'b0, 16'd0, 0); next_cycle();
    rst = 1'b0;
    req_valid = 4'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rs_post%0d.resp_valid", i), 32'(resp_valid), 32'd0);
      chk($sformatf("rs_post%0d.resp_data", i), 32'(resp_data), 32'd0);
      next_cycle();
    end
    req_valid = 4'b1111;
    @(negedge clk); chk_all("rs_grant", 4'b0001, 1, 16'd1, 16'd10, 4'b0, 16'd0, 0); next_cycle();
    req_valid = 4'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_16_16_arbiter.md
Name: mult_16_16_arbiter

Overview:
Round-robin arbiter/scheduler that shares one fully pipelined 16x16 multiplier among NREQ requesters. Each requester issues operand pairs over a valid/ready handshake. The arbiter drives the multiplier's a/b/en inputs and tracks the owner of every in-flight operation in a tag pipeline. Each product is routed back to its issuing requester exactly LAT cycles after issue. The block sits between the client datapaths and mult_16_16.

Parameters:
NREQ, 4, number of requesters (2..8)
LAT, 3, multiplier latency in cycles from an issue edge to a valid mul_out (1..16)
W, 16, operand and result width

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
req_valid  in  NREQ  per-requester operand valid
req_ready  out  NREQ  per-requester grant (one-hot or zero)
req_a  in  NREQ*W  packed operand A; requester i uses bits [i*W +: W]
req_b  in  NREQ*W  packed operand B; same packing as req_a
flush  in  1  block new issues and let the pipeline drain
mul_a  out  W  multiplier operand A
mul_b  out  W  multiplier operand B
mul_en  out  1  issue strobe to multiplier
mul_out  in  W  multiplier result (low W bits of the product)
resp_valid  out  NREQ  one-cycle result strobe, one-hot or zero
resp_data  out  W  result data, shared by all requesters
busy  out  1  at least one operation in flight

Behaviour:
- Reset (async, while rst=1):
  - rr_ptr=0; tag pipeline all invalid; state=RUN.
  - resp_valid=0, busy=0.
  - req_ready=0, mul_en=0, mul_a=0, mul_b=0 are forced while rst=1.
- Arbitration (combinational):
  - In RUN, pick the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ. Assert req_ready[i] only.
  - In DRAIN, or with no valid requester, req_ready=0.
- Issue: an issue occurs in any cycle where req_valid[i] & req_ready[i].
  - mul_en=1; mul_a/mul_b = req_a/req_b slice i.
  - On that edge rr_ptr <= (i+1) mod NREQ.
  - With no issue: mul_en=0, mul_a=mul_b=0, rr_ptr unchanged.
- At most one issue per cycle. Throughput is one op/cycle overall. A continuously valid requester is served at least once every NREQ cycles.
- Tag pipeline: LAT stages, each holding {vld, tag[clog2(NREQ)-1:0]}.
  - Stage 0 loads {issue, i} every edge; stage k loads stage k-1.
  - It always advances, including bubbles. The multiplier is treated as free-running.
- Response: resp_valid[tag]=1 iff the last stage has vld=1. resp_data=mul_out, combinational passthrough, else 0.
  - For an issue sampled at edge E, the response is visible in the cycle after edge E+LAT-1 (LAT edges inclusive).
  - There is no response backpressure; requesters must accept it.
- Arithmetic: product truncated to W bits by the multiplier; the arbiter never alters data.
- busy = OR of all tag-stage vld bits (registered stages only).
- State machine:
  - RUN -> DRAIN when flush=1 (same-cycle effect: req_ready=0 combinationally while flush=1).
  - DRAIN -> RUN when flush=0 and busy=0.
  - DRAIN with flush=0 and busy=1 stays in DRAIN until the pipe empties.
- Boundary conditions:
  - Requester deasserts valid before ready: no issue, pointer unchanged.
  - All requesters valid: strict rotation 0,1,2,3,0,...
  - Issue and response for the same requester in the same cycle are both honoured.
  - Reset mid-operation discards all in-flight tags; no resp_valid follows even if the multiplier later emits data.

Test Plan:
1. NREQ=4, LAT=3; req 2 sends a=2, b=3 alone -> req_ready=0100 that cycle; mul_en pulse, mul_a=2, mul_b=3; resp_valid=0100, resp_data=6 three edges later; rr_ptr=3.
2. All four valid continuously, a=i+1, b=10 -> grants 0,1,2,3,0; responses 10,20,30,40,10 arrive in the same order, with resp_valid one-hot matching each issuer.
3. Req 0 and 3 valid with rr_ptr=1 -> req 3 granted first, then 0; req 0 is not granted twice before req 3.
4. Issue 3 back-to-back ops, then flush=1 -> req_ready=0 immediately; busy stays 1 until the 3rd response, then 0; state returns to RUN one cycle after flush drops with busy=0.
5. Issue 2 ops, assert rst one cycle later -> all outputs 0 immediately; no resp_valid for either op after release; next grant starts at requester 0.
6. a=16'hFFFF, b=2 -> resp_data=16'hFFFE (truncation passthrough).
